ram_master: RTL and testbench
=============================

# ram_master

Bus initiator for the 32-bit RAM's shared tri-state data bus. It accepts single-beat read and write requests from the core over a valid/ready handshake. It sequences `rdEn`, `wrEn` and `addr`, and drives or releases `data` with a guaranteed bus turnaround. Read data is returned on a one-cycle response strobe. It sits between the core's load/store path and the RAM instance.

## Interface
- `DWIDTH`, default 32: data and bus width.
- `MEMDEPTH`, default 256: RAM depth in words.
- `AWIDTH`, default `$clog2(MEMDEPTH)`: address width.

Ports:
- `clk`  in  1: single clock; all state updates on posedge.
- `rst`  in  1: reset, asynchronous, active-low.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: master can accept a request this cycle.
- `req_we`  in  1: 1 = write, 0 = read.
- `req_addr`  in  AWIDTH: word address.
- `req_wdata`  in  DWIDTH: write data.
- `resp_valid`  out  1: one-cycle strobe, read data valid.
- `resp_data`  out  DWIDTH: registered read data.
- `data`  inout  DWIDTH: RAM bus; driven only in WRITE, otherwise high-Z.
- `rdEn`  out  1: RAM read enable.
- `wrEn`  out  1: RAM write enable.
- `addr`  out  AWIDTH: RAM address.

## Operation
- FSM states: IDLE, WRITE, RD_ADDR, RD_DATA, TURN.
- `req_ready` = 1 only in IDLE. A request is accepted on a posedge with `req_valid && req_ready`. `req_we`, `req_addr` and `req_wdata` are latched at that edge.
- IDLE → WRITE on an accepted write.
  - In WRITE: `wrEn`=1, `addr` = latched address, `data` driven with the latched write data.
  - WRITE → IDLE. The RAM captures the write at the posedge ending WRITE.
- IDLE → RD_ADDR on an accepted read.
  - In RD_ADDR and RD_DATA: `rdEn`=1, `addr` held, `data` released.
  - RD_ADDR → RD_DATA.
  - At the posedge ending RD_DATA, `data` is captured into `resp_data`.
  - RD_DATA → TURN.
- In TURN:
  - `resp_valid`=1 for exactly this cycle.
  - `rdEn`=0, `wrEn`=0, bus released.
  - TURN → IDLE.
- `rdEn`, `wrEn`, `addr` and the bus drive enable are registered outputs. There are no combinational paths from `req_*` to RAM-side pins.
- Invariant: `rdEn && wrEn` is never 1. `data` is never driven while `rdEn`=1 or in the cycle after `rdEn` falls.
- `addr` keeps its last value in IDLE and TURN. `resp_data` holds until the next read capture.
- Request fields are ignored when no request is accepted. `req_valid` is not required to stay asserted while `req_ready`=0.

## Timing
- Reset (asynchronous assert, `rst`=0):
  - State = IDLE; `rdEn`=0, `wrEn`=0, `addr`=0.
  - `data` = high-Z, `resp_valid`=0, `resp_data`=0.
  - `req_ready`=1 once `rst`=1.
- Write: accepted at edge E0. WRITE occupies cycle E0–E1 and the RAM writes at E1. `req_ready`=1 again in cycle E1–E2, so the write rate is 1 per 2 cycles.
- Read: accepted at E0. RD_ADDR is E0–E1, RD_DATA is E1–E2, data is captured at E2. `resp_valid`=1 in cycle E2–E3. `req_ready`=1 again from E3, so the read rate is 1 per 4 cycles. Read latency is 3 cycles from accept to `resp_valid`.
- Read followed by write: the first `wrEn`/drive cycle is at least 2 cycles after `rdEn` falls.
- Reset asserted mid-transaction:
  - Bus released and enables cleared immediately (asynchronously).
  - The in-flight read produces no `resp_valid`.
  - An in-flight write may be lost.
- Address boundaries: addresses 0 and MEMDEPTH-1 need no special handling. There is no wrap or increment logic.

## Structure
- Shared package `ram_pkg`:
  - `DWIDTH`, `MEMDEPTH`, `AWIDTH` constants.
  - State enum type `ram_master_state_t`.
- The RAM testbench and the core import the same package.
- Flops use the codebase's `DFFR` macro with async active-low `rst`.
- No sub-module. The tri-state driver is a single continuous assign gated by the registered drive enable.

## Test plan
- Reset: hold `rst`=0 with `req_valid`=1. Expect `rdEn`=`wrEn`=0, `data`=Z, `resp_valid`=0, `addr`=0, and no accept.
- Write then read: write 0xDEADBEEF to addr 0x05, then read addr 0x05. Expect `resp_valid` 3 cycles after the read accept with `resp_data`=0xDEADBEEF.
- Boundary addresses: write 0xA5A5A5A5 to addr 0xFF and 0x5A5A5A5A to addr 0x00, then read both back. Expect the same values in the same order.
- Back-to-back alternation: 32 random write/read pairs at alternating addresses 1, 3, 2, 4… with `req_valid` held high. Expect:
  - No cycle with `rdEn && wrEn`.
  - No bus contention (no X on `data`).
  - At least 2 released cycles between `rdEn` falling and the next drive.
  - All read data matching.
- Reset mid-read: assert `rst`=0 during RD_DATA. Expect immediate `rdEn`=0, no `resp_valid`, and IDLE with `req_ready`=1 after release.
- Backpressure: pulse `req_valid` for one cycle while in RD_DATA. Expect the request to be ignored and no second transaction.

Source files
------------

// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared RAM geometry constants and master FSM state type
package ram_pkg;

  localparam int DWIDTH   = 32;
  localparam int MEMDEPTH = 256;
  localparam int AWIDTH   = $clog2(MEMDEPTH);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_ADDR,
    RD_DATA,
    TURN
  } ram_master_state_t;

endpackage

// File: rtl/ram_master.sv
// rtl/ram_master.sv - single-beat read/write initiator for the RAM's shared tri-state data bus
module ram_master #(
  parameter int DWIDTH   = ram_pkg::DWIDTH,
  parameter int MEMDEPTH = ram_pkg::MEMDEPTH,
  parameter int AWIDTH   = $clog2(MEMDEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DWIDTH-1:0] resp_data,
  inout  wire  [DWIDTH-1:0] data,
  output logic              rdEn,
  output logic              wrEn,
  output logic [AWIDTH-1:0] addr
);
  import ram_pkg::*;

  ram_master_state_t state;
  logic              drive_en;
  logic [DWIDTH-1:0] wdata_q;

  // Only drive_en gates the bus, and it is a flop, so no request pin can glitch the RAM side.
  assign data      = drive_en ? wdata_q : {DWIDTH{1'bz}};
  assign req_ready = rst && (state == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      rdEn       <= 1'b0;
      wrEn       <= 1'b0;
      drive_en   <= 1'b0;
      addr       <= '0;
      wdata_q    <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr <= req_addr;
            if (req_we) begin
              state    <= WRITE;
              wrEn     <= 1'b1;
              drive_en <= 1'b1;
              wdata_q  <= req_wdata;
            end else begin
              state <= RD_ADDR;
              rdEn  <= 1'b1;
            end
          end
        end
        WRITE: begin
          state    <= IDLE;
          wrEn     <= 1'b0;
          drive_en <= 1'b0;
        end
        RD_ADDR: begin
          state <= RD_DATA;
        end
        RD_DATA: begin
          // TURN plus the following IDLE cycle give the RAM two released cycles before any write drive.
          state      <= TURN;
          rdEn       <= 1'b0;
          resp_data  <= data;
          resp_valid <= 1'b1;
        end
        TURN: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          rdEn       <= 1'b0;
          wrEn       <= 1'b0;
          drive_en   <= 1'b0;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_master.sv
// tb/tb_ram_master.sv - directed self-checking bench for ram_master with a behavioural RAM on the bus
module tb_ram_master;
  import ram_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [AWIDTH-1:0] req_addr = '0;
  logic [DWIDTH-1:0] req_wdata = '0;
  logic              resp_valid;
  logic [DWIDTH-1:0] resp_data;
  wire  [DWIDTH-1:0] data;
  logic              rdEn;
  logic              wrEn;
  logic [AWIDTH-1:0] addr;

  int n_checks = 0;
  int n_errors = 0;

  logic              probe_en = 1'b0;
  logic [DWIDTH-1:0] probe_val = 32'h1357_9BDF;
  logic [DWIDTH-1:0] ram [MEMDEPTH];
  logic [DWIDTH-1:0] ram_q = '0;
  logic [DWIDTH-1:0] model [MEMDEPTH];

  logic              mon_en = 1'b0;
  int                gap = 100;
  int                n_resp = 0;
  logic [DWIDTH-1:0] exp_q [$];
  logic [DWIDTH-1:0] lat_wdata = '0;

  ram_master dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .data       (data),
    .rdEn       (rdEn),
    .wrEn       (wrEn),
    .addr       (addr)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM: samples addr while rdEn is high and drives the bus only while rdEn is high.
  assign data = rdEn ? ram_q : {DWIDTH{1'bz}};
  assign data = probe_en ? probe_val : {DWIDTH{1'bz}};

  always @(posedge clk) begin
    if (wrEn) ram[addr] <= data;
    if (rdEn) ram_q <= ram[addr];
  end

  task automatic check(input string tag, input logic [DWIDTH-1:0] got, input logic [DWIDTH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_released(input string tag);
    probe_en = 1'b1;
    #1;
    check(tag, data, probe_val);
    probe_en = 1'b0;
    #1;
  endtask

  task automatic do_write(input logic [AWIDTH-1:0] a, input logic [DWIDTH-1:0] d);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    check("wr_ready", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("wr_wren", wrEn, 1);
    check("wr_rden", rdEn, 0);
    check("wr_addr", addr, a);
    check("wr_bus", data, d);
    @(negedge clk);
    check("wr_done_wren", wrEn, 0);
    check("wr_done_ready", req_ready, 1);
  endtask

  task automatic do_read(input logic [AWIDTH-1:0] a, input logic [DWIDTH-1:0] exp);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = 32'hFFFF_0000;
    check("rd_ready", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rd_addr_rden", rdEn, 1);
    check("rd_addr_wren", wrEn, 0);
    check("rd_addr_addr", addr, a);
    check("rd_addr_resp", resp_valid, 0);
    @(negedge clk);
    check("rd_data_rden", rdEn, 1);
    check("rd_data_resp", resp_valid, 0);
    @(negedge clk);
    check("rd_turn_resp_valid", resp_valid, 1);
    check("rd_turn_resp_data", resp_data, exp);
    check("rd_turn_rden", rdEn, 0);
    check("rd_turn_ready", req_ready, 0);
    check_released("rd_turn_bus_released");
    @(negedge clk);
    check("rd_idle_resp_valid", resp_valid, 0);
    check("rd_idle_ready", req_ready, 1);
    check("rd_idle_resp_hold", resp_data, exp);
    check("rd_idle_addr_hold", addr, a);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("b2b_rd_wr_overlap", rdEn & wrEn, 0);
      if (wrEn) begin
        check("b2b_turnaround_gap", gap >= 2, 1);
        check("b2b_bus_drive", data, lat_wdata);
      end
      if (rdEn) gap = 0;
      else if (gap < 100) gap++;
      if (resp_valid) begin
        n_resp++;
        if (exp_q.size() > 0) check("b2b_rdata", resp_data, exp_q.pop_front());
        else check("b2b_extra_resp", 1, 0);
      end
    end
  end

  initial begin
    int budget;
    int busy;
    logic [AWIDTH-1:0] a;
    logic [DWIDTH-1:0] wd;

    // Reset held with a pending write request: nothing may be accepted.
    #1;
    rst = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h33; req_wdata = 32'hCAFE_F00D;
    repeat (3) @(negedge clk);
    check("rst_rden", rdEn, 0);
    check("rst_wren", wrEn, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_addr", addr, 0);
    check("rst_resp_data", resp_data, 0);
    check_released("rst_bus_released");
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_release_ready", req_ready, 1);
    @(negedge clk);

    do_write(8'h05, 32'hDEAD_BEEF);
    do_read(8'h05, 32'hDEAD_BEEF);

    do_write(8'hFF, 32'hA5A5_A5A5);
    do_write(8'h00, 32'h5A5A_5A5A);
    do_read(8'hFF, 32'hA5A5_A5A5);
    do_read(8'h00, 32'h5A5A_5A5A);

    // Back-to-back write/read pairs with req_valid held high.
    mon_en = 1'b1;
    gap = 100;
    for (int i = 0; i < 64; i++) begin
      int p;
      p = i / 2;
      a = AWIDTH'(p / 2 + 1 + (p % 2) * 2);
      req_valid = 1'b1;
      req_addr = a;
      if (i % 2 == 0) begin
        wd = $urandom;
        req_we = 1'b1;
        req_wdata = wd;
      end else begin
        req_we = 1'b0;
        req_wdata = ~model[a];
      end
      budget = 0;
      while (!req_ready && budget < 10) begin
        @(negedge clk);
        budget++;
      end
      if (!req_ready) check("b2b_accept_timeout", 0, 1);
      if (i % 2 == 0) begin
        model[a] = wd;
        lat_wdata = wd;
      end else begin
        exp_q.push_back(model[a]);
      end
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    mon_en = 1'b0;
    check("b2b_resp_count", n_resp, 32);
    check("b2b_resp_pending", exp_q.size(), 0);

    // Reset asserted during RD_DATA.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h05;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #2;
    check("midrd_rden_before", rdEn, 1);
    rst = 1'b0;
    #1;
    check("midrd_rden_async", rdEn, 0);
    check_released("midrd_bus_released");
    busy = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid || rdEn) busy++;
    end
    check("midrd_no_resp_in_reset", busy, 0);
    rst = 1'b1;
    #1;
    check("midrd_ready_after", req_ready, 1);
    busy = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid || rdEn || wrEn) busy++;
    end
    check("midrd_no_resp_after", busy, 0);

    // Request pulsed during RD_DATA must be ignored.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("bp_ready_in_rd_data", req_ready, 0);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h77; req_wdata = 32'h1111_1111;
    @(negedge clk);
    req_valid = 1'b0;
    check("bp_resp_valid", resp_valid, 1);
    check("bp_resp_data", resp_data, 32'hA5A5_A5A5);
    busy = 0;
    repeat (4) begin
      @(negedge clk);
      if (rdEn || wrEn || resp_valid) busy++;
    end
    check("bp_no_second_txn", busy, 0);
    check("bp_final_ready", req_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
